// File: rtl/udp_cmd_rx.sv
// udp_cmd_rx: MII receive parser for a single UDP/IPv4 command frame.
//   Watches the 4-bit receive stream. It accepts a frame addressed to this
//   board (MAC or broadcast, IPv4, UDP, local IP and local port) and captures
//   the first 32-bit payload word. At end of frame it pulses rx_finish, which
//   starts the transmit engine's response. The FCS is not checked here.
// Ports:
//   clk        MII receive clock (single domain)
//   clr        synchronous active-high reset
//   rx_dv      MII receive data valid
//   rxd[3:0]   MII receive nibble, low nibble of each byte first
//   udp_tx_cmd last accepted command word; holds between frames
//   rx_finish  one-cycle pulse: frame accepted, udp_tx_cmd updated
//   rx_drop    one-cycle pulse: frame rejected or truncated after SFD
//   rx_busy    high from the nibble after SFD until the finish/drop pulse
module udp_cmd_rx #(
  parameter logic [47:0] LOCAL_MAC    = 48'h01606E11020F,
  parameter logic [31:0] LOCAL_IP     = 32'hC0A801B7,
  parameter logic [15:0] LOCAL_PORT   = 16'h1F90,
  parameter bit          ACCEPT_BCAST = 1'b1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        rx_dv,
  input  logic [3:0]  rxd,
  output logic [31:0] udp_tx_cmd,
  output logic        rx_finish,
  output logic        rx_drop,
  output logic        rx_busy
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_HEADER   = 3'd2,
    ST_PAYLOAD  = 3'd3,
    ST_WAIT_END = 3'd4,
    ST_DRAIN    = 3'd5
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic        prev_dv_r;
  logic [1:0]  pre_cnt_r;
  logic        phase_r;
  logic [3:0]  lo_nib_r;
  logic [5:0]  byte_cnt_r;
  logic        uni_ok_r;
  logic        bc_ok_r;
  logic [31:0] shadow_r;
  logic [31:0] udp_tx_cmd_r;
  logic        rx_finish_r;
  logic        rx_drop_r;
  logic        rx_busy_r;

  logic [7:0]  byte_s;
  logic        in_frame_s;
  logic        byte_done_s;
  logic        uni_ok_s;
  logic        bc_ok_s;
  logic        hdr_ok_s;
  logic [8:0]  rule_s;
  logic        finish_s;
  logic        drop_s;
  logic        busy_s;

  // Destination MAC byte at header offset idx (0..5), MSB byte first.
  function automatic logic [7:0] mac_byte(input logic [5:0] idx);
    case (idx)
      6'd0:    mac_byte = LOCAL_MAC[47:40];
      6'd1:    mac_byte = LOCAL_MAC[39:32];
      6'd2:    mac_byte = LOCAL_MAC[31:24];
      6'd3:    mac_byte = LOCAL_MAC[23:16];
      6'd4:    mac_byte = LOCAL_MAC[15:8];
      6'd5:    mac_byte = LOCAL_MAC[7:0];
      default: mac_byte = 8'h00;
    endcase
  endfunction

  // Fixed header bytes beyond the MAC: {must_check, expected_value}.
  function automatic logic [8:0] hdr_rule(input logic [5:0] idx);
    case (idx)
      6'd12:   hdr_rule = {1'b1, 8'h08};
      6'd13:   hdr_rule = {1'b1, 8'h00};
      6'd14:   hdr_rule = {1'b1, 8'h45};
      6'd23:   hdr_rule = {1'b1, 8'h11};
      6'd30:   hdr_rule = {1'b1, LOCAL_IP[31:24]};
      6'd31:   hdr_rule = {1'b1, LOCAL_IP[23:16]};
      6'd32:   hdr_rule = {1'b1, LOCAL_IP[15:8]};
      6'd33:   hdr_rule = {1'b1, LOCAL_IP[7:0]};
      6'd36:   hdr_rule = {1'b1, LOCAL_PORT[15:8]};
      6'd37:   hdr_rule = {1'b1, LOCAL_PORT[7:0]};
      default: hdr_rule = {1'b0, 8'h00};
    endcase
  endfunction

  assign byte_s      = {rxd, lo_nib_r};
  assign in_frame_s  = (state_r == ST_HEADER) || (state_r == ST_PAYLOAD) ||
                       (state_r == ST_WAIT_END) || (state_r == ST_DRAIN);
  assign byte_done_s = in_frame_s && rx_dv && phase_r;
  assign rule_s      = hdr_rule(byte_cnt_r);

  // Header byte check; the MAC passes if either unicast or broadcast still matches.
  always_comb begin
    uni_ok_s = uni_ok_r;
    bc_ok_s  = bc_ok_r;
    hdr_ok_s = 1'b1;
    if (byte_cnt_r < 6'd6) begin
      uni_ok_s = uni_ok_r && (byte_s == mac_byte(byte_cnt_r));
      bc_ok_s  = bc_ok_r && ACCEPT_BCAST && (byte_s == 8'hFF);
      hdr_ok_s = uni_ok_s || bc_ok_s;
    end else begin
      hdr_ok_s = !rule_s[8] || (byte_s == rule_s[7:0]);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!prev_dv_r && rx_dv && (rxd == 4'h5)) state_s = ST_PREAMBLE;
        else                                      state_s = ST_IDLE;
      end
      ST_PREAMBLE: begin
        if (!rx_dv)                                       state_s = ST_IDLE;
        else if (rxd == 4'h5)                             state_s = ST_PREAMBLE;
        else if ((rxd == 4'hD) && (pre_cnt_r == 2'd2))    state_s = ST_HEADER;
        else                                              state_s = ST_IDLE;
      end
      ST_HEADER: begin
        if (!rx_dv)                                 state_s = ST_IDLE;
        else if (byte_done_s && !hdr_ok_s)          state_s = ST_DRAIN;
        else if (byte_done_s && byte_cnt_r == 6'd41) state_s = ST_PAYLOAD;
        else                                        state_s = ST_HEADER;
      end
      ST_PAYLOAD: begin
        if (!rx_dv)                                  state_s = ST_IDLE;
        else if (byte_done_s && byte_cnt_r == 6'd45) state_s = ST_WAIT_END;
        else                                         state_s = ST_PAYLOAD;
      end
      ST_WAIT_END: begin
        if (!rx_dv) state_s = ST_IDLE;
        else        state_s = ST_WAIT_END;
      end
      ST_DRAIN: begin
        if (!rx_dv) state_s = ST_IDLE;
        else        state_s = ST_DRAIN;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Output decode; the results are registered so pulses follow the rx_dv=0 sample by one clock.
  always_comb begin
    finish_s = (state_r == ST_WAIT_END) && !rx_dv;
    drop_s   = !rx_dv && ((state_r == ST_HEADER) || (state_r == ST_PAYLOAD) ||
                          (state_r == ST_DRAIN));
    busy_s   = (state_s == ST_HEADER) || (state_s == ST_PAYLOAD) ||
               (state_s == ST_WAIT_END) || (state_s == ST_DRAIN);
  end

  // Datapath: byte assembly, counters, header flags, payload shadow and outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      // prev_dv resets high so a frame still in flight cannot look like a new rising edge.
      prev_dv_r    <= 1'b1;
      pre_cnt_r    <= 2'd0;
      phase_r      <= 1'b0;
      lo_nib_r     <= 4'h0;
      byte_cnt_r   <= 6'd0;
      uni_ok_r     <= 1'b1;
      bc_ok_r      <= 1'b1;
      shadow_r     <= 32'h0000_0000;
      udp_tx_cmd_r <= 32'h0000_0000;
      rx_finish_r  <= 1'b0;
      rx_drop_r    <= 1'b0;
      rx_busy_r    <= 1'b0;
    end else begin
      prev_dv_r   <= rx_dv;
      rx_finish_r <= finish_s;
      rx_drop_r   <= drop_s;
      rx_busy_r   <= busy_s;
      // The rising-edge nibble is the first 5 of the preamble.
      if (state_r == ST_IDLE) begin
        pre_cnt_r <= 2'd1;
      end else if ((state_r == ST_PREAMBLE) && (rxd == 4'h5) && (pre_cnt_r != 2'd2)) begin
        pre_cnt_r <= pre_cnt_r + 2'd1;
      end
      if (state_r == ST_PREAMBLE) begin
        phase_r    <= 1'b0;
        byte_cnt_r <= 6'd0;
        uni_ok_r   <= 1'b1;
        bc_ok_r    <= 1'b1;
      end else if (in_frame_s && rx_dv) begin
        phase_r <= ~phase_r;
        if (!phase_r) begin
          lo_nib_r <= rxd;
        end else if (byte_cnt_r != 6'd63) begin
          byte_cnt_r <= byte_cnt_r + 6'd1;
        end
        if (byte_done_s && (state_r == ST_HEADER)) begin
          uni_ok_r <= uni_ok_s;
          bc_ok_r  <= bc_ok_s;
        end
        if (byte_done_s && (state_r == ST_PAYLOAD)) begin
          shadow_r <= {shadow_r[23:0], byte_s};
        end
      end
      if (finish_s) begin
        udp_tx_cmd_r <= shadow_r;
      end
    end
  end

  assign udp_tx_cmd = udp_tx_cmd_r;
  assign rx_finish  = rx_finish_r;
  assign rx_drop    = rx_drop_r;
  assign rx_busy    = rx_busy_r;

endmodule

// File: tb/tb_udp_cmd_rx.sv
// tb_udp_cmd_rx: randomized self-checking bench for udp_cmd_rx.
//   Two instances share the stimulus: one accepts broadcast MAC, one does not.
//   Expected outcomes come from a byte-level model of the acceptance rules.
module tb_udp_cmd_rx;

  localparam logic [47:0] MAC  = 48'h01606E11020F;
  localparam logic [31:0] IP   = 32'hC0A801B7;
  localparam logic [15:0] PORT = 16'h1F90;

  logic        clk = 1'b0;
  logic        clr;
  logic        rx_dv;
  logic [3:0]  rxd;
  logic [31:0] cmd_b, cmd_n;
  logic        fin_b, drop_b, busy_b;
  logic        fin_n, drop_n, busy_n;

  always #5 clk = ~clk;

  udp_cmd_rx #(.ACCEPT_BCAST(1'b1)) dut_b (
    .clk(clk), .clr(clr), .rx_dv(rx_dv), .rxd(rxd),
    .udp_tx_cmd(cmd_b), .rx_finish(fin_b), .rx_drop(drop_b), .rx_busy(busy_b)
  );

  udp_cmd_rx #(.ACCEPT_BCAST(1'b0)) dut_n (
    .clk(clk), .clr(clr), .rx_dv(rx_dv), .rxd(rxd),
    .udp_tx_cmd(cmd_n), .rx_finish(fin_n), .rx_drop(drop_n), .rx_busy(busy_n)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0]  frm [0:79];
  int          frm_len;
  logic [31:0] exp_cmd_b, exp_cmd_n;

  // Pulse counters, sampled shortly after each rising edge.
  int fin_cnt_b = 0, drop_cnt_b = 0, fin_cnt_n = 0, drop_cnt_n = 0;
  int snap_fb, snap_db, snap_fn, snap_dn;

  // Count every finish/drop pulse cycle on both instances.
  always @(posedge clk) begin
    #2;
    if (fin_b)  fin_cnt_b++;
    if (drop_b) drop_cnt_b++;
    if (fin_n)  fin_cnt_n++;
    if (drop_n) drop_cnt_n++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic nib(input logic dv, input logic [3:0] d, input logic c);
    @(negedge clk);
    rx_dv = dv;
    rxd   = d;
    clr   = c;
  endtask

  // Well-formed frame with random ignored bytes and random trailer.
  task automatic build_frame(input logic [47:0] dmac, input logic [15:0] port,
                             input logic [31:0] pay, input int len);
    for (int i = 0; i < 80; i++) frm[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) frm[i] = dmac[47-8*i -: 8];
    frm[12] = 8'h08; frm[13] = 8'h00; frm[14] = 8'h45; frm[23] = 8'h11;
    for (int i = 0; i < 4; i++) frm[30+i] = IP[31-8*i -: 8];
    frm[36] = port[15:8]; frm[37] = port[7:0];
    for (int i = 0; i < 4; i++) frm[42+i] = pay[31-8*i -: 8];
    frm_len = len;
  endtask

  // Reference: 0 = no pulse, 1 = finish, 2 = drop, for a frame with a valid SFD.
  function automatic int outcome(input bit bc);
    logic [47:0] m;
    m = {frm[0], frm[1], frm[2], frm[3], frm[4], frm[5]};
    if (frm_len < 46) return 2;
    if (!(m == MAC || (bc && m == 48'hFFFF_FFFF_FFFF))) return 2;
    if ({frm[12], frm[13]} != 16'h0800) return 2;
    if (frm[14] != 8'h45) return 2;
    if (frm[23] != 8'h11) return 2;
    if ({frm[30], frm[31], frm[32], frm[33]} != IP) return 2;
    if ({frm[36], frm[37]} != PORT) return 2;
    return 1;
  endfunction

  // Send preamble, SFD and frm[0..frm_len-1]; optionally pulse clr at byte clr_at.
  task automatic run_frame(input string name, input int pre_len, input logic [3:0] sfd,
                           input int clr_at, input int gap);
    bit sfd_ok;
    int ob, on;
    sfd_ok = (sfd == 4'hD) && (pre_len >= 2) && (clr_at < 0);
    ob = sfd_ok ? outcome(1'b1) : 0;
    on = sfd_ok ? outcome(1'b0) : 0;
    for (int i = 0; i < pre_len; i++) nib(1'b1, 4'h5, 1'b0);
    nib(1'b1, sfd, 1'b0);
    for (int b = 0; b < frm_len; b++) begin
      nib(1'b1, frm[b][3:0], (b == clr_at) ? 1'b1 : 1'b0);
      nib(1'b1, frm[b][7:4], 1'b0);
    end
    if (clr_at >= 0) begin
      exp_cmd_b = 32'h0;
      exp_cmd_n = 32'h0;
    end
    @(negedge clk);
    check_val({name, ".busy_b"}, {31'h0, busy_b}, {31'h0, sfd_ok});
    check_val({name, ".hold_b"}, cmd_b, exp_cmd_b);
    check_val({name, ".hold_n"}, cmd_n, exp_cmd_n);
    rx_dv = 1'b0;
    rxd   = 4'h0;
    @(negedge clk);
    if (ob == 1) exp_cmd_b = {frm[42], frm[43], frm[44], frm[45]};
    if (on == 1) exp_cmd_n = {frm[42], frm[43], frm[44], frm[45]};
    check_val({name, ".fin_b"},  {31'h0, fin_b},  {31'h0, ob == 1});
    check_val({name, ".drop_b"}, {31'h0, drop_b}, {31'h0, ob == 2});
    check_val({name, ".fin_n"},  {31'h0, fin_n},  {31'h0, on == 1});
    check_val({name, ".drop_n"}, {31'h0, drop_n}, {31'h0, on == 2});
    check_val({name, ".busy_end"}, {31'h0, busy_b | busy_n}, 32'h0);
    check_val({name, ".cmd_b"}, cmd_b, exp_cmd_b);
    check_val({name, ".cmd_n"}, cmd_n, exp_cmd_n);
    // Pulse totals since the previous frame's pulse cycle: catches stray or stretched pulses.
    check_val({name, ".nfin_b"},  fin_cnt_b - snap_fb,  (ob == 1) ? 32'd1 : 32'd0);
    check_val({name, ".ndrop_b"}, drop_cnt_b - snap_db, (ob == 2) ? 32'd1 : 32'd0);
    check_val({name, ".nfin_n"},  fin_cnt_n - snap_fn,  (on == 1) ? 32'd1 : 32'd0);
    check_val({name, ".ndrop_n"}, drop_cnt_n - snap_dn, (on == 2) ? 32'd1 : 32'd0);
    snap_fb = fin_cnt_b; snap_db = drop_cnt_b; snap_fn = fin_cnt_n; snap_dn = drop_cnt_n;
    for (int g = 1; g < gap; g++) nib(1'b0, 4'h0, 1'b0);
  endtask

  initial begin
    int kind, idx;
    clr = 1'b1; rx_dv = 1'b0; rxd = 4'h0;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    check_val("rst.cmd_b", cmd_b, 32'h0);
    check_val("rst.cmd_n", cmd_n, 32'h0);
    check_val("rst.pulses", {30'h0, fin_b | fin_n, drop_b | drop_n}, 32'h0);
    check_val("rst.busy", {31'h0, busy_b | busy_n}, 32'h0);
    exp_cmd_b = 32'h0; exp_cmd_n = 32'h0;
    snap_fb = fin_cnt_b; snap_db = drop_cnt_b; snap_fn = fin_cnt_n; snap_dn = drop_cnt_n;

    build_frame(MAC, PORT, 32'h12345678, 68);          run_frame("uni", 15, 4'hD, -1, 2);
    build_frame(48'hFFFF_FFFF_FFFF, PORT, 32'hA5A55A5A, 68); run_frame("bcast", 15, 4'hD, -1, 2);
    build_frame(MAC, 16'h1F91, 32'h11112222, 68);      run_frame("port", 15, 4'hD, -1, 2);
    build_frame(MAC, PORT, 32'h33334444, 44);          run_frame("trunc", 15, 4'hD, -1, 2);
    build_frame(MAC, PORT, 32'h55556666, 68);          run_frame("clr", 15, 4'hD, 20, 2);
    build_frame(MAC, PORT, 32'hDEADBEEF, 68);          run_frame("after_clr", 15, 4'hD, -1, 2);
    build_frame(MAC, PORT, 32'h00000001, 64);          run_frame("b2b1", 15, 4'hD, -1, 1);
    build_frame(MAC, PORT, 32'h00000002, 64);          run_frame("b2b2", 15, 4'hD, -1, 2);
    build_frame(MAC, PORT, 32'h77778888, 64);          run_frame("badpre", 3, 4'hC, -1, 2);
    build_frame(MAC, PORT, 32'h9999AAAA, 46);          run_frame("min46", 15, 4'hD, -1, 2);
    build_frame(MAC, PORT, 32'hBBBBCCCC, 45);          run_frame("short45", 15, 4'hD, -1, 2);

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 8);
      build_frame((kind == 1) ? 48'hFFFF_FFFF_FFFF : MAC, PORT, $urandom,
                  $urandom_range(46, 78));
      case (kind)
        2: idx = $urandom_range(0, 5);
        3: idx = $urandom_range(12, 13);
        4: idx = 14;
        5: idx = 23;
        6: idx = $urandom_range(30, 33);
        7: idx = $urandom_range(36, 37);
        default: idx = -1;
      endcase
      if (idx >= 0) frm[idx] = frm[idx] ^ (8'h01 << $urandom_range(0, 7));
      if (kind == 8) frm_len = $urandom_range(1, 45);
      run_frame("rnd", $urandom_range(7, 15), 4'hD, -1, $urandom_range(1, 3));
    end

    repeat (3) nib(1'b0, 4'h0, 1'b0);
    check_val("tail.nfin",  (fin_cnt_b - snap_fb) + (fin_cnt_n - snap_fn), 32'd0);
    check_val("tail.ndrop", (drop_cnt_b - snap_db) + (drop_cnt_n - snap_dn), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
